// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, single-outstanding memory read, instruction register
// Moore FSM IDLE/FETCH/WAIT/HOLD; redirects replace fetch_pc and squash the stale response.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus1,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              drop_q, drop_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_pc_q <= RESET_PC;
      instr_q    <= 16'h0000;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        // The request already went out; its response must be squashed.
        state_d = WAIT;
        if (redirect) begin
          fetch_pc_d = redirect_target;
          drop_d     = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = FETCH;
            if (redirect) begin
              fetch_pc_d = redirect_target;
            end
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            state_d    = HOLD;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_target;
          drop_d     = 1'b1;
        end
      end
      HOLD: begin
        // fetch_pc was advanced at capture, so a plain accept just refetches.
        if (redirect) begin
          fetch_pc_d = redirect_target;
          state_d    = FETCH;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_read    = (state_q == FETCH);
  assign instr_valid = (state_q == HOLD);
  assign mem_addr    = fetch_pc_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus1    = instr_pc_q + ADDR_W'(1);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle 16-bit processor. Owns the program counter, issues one word read at a time to instruction memory, and captures the returned word into the instruction register. Presents it to the control state machine with a valid/ready handshake. Accepts branch and jump redirects from the execute side and discards any in-flight fetch they make stale.

## Interface
Parameters:
- ADDR_W, 16, program counter and memory address width (word addressed)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  input  1  rising-edge clock, sole clock
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
- mem_read  output  1  single-cycle read request to instruction memory
- mem_addr  output  ADDR_W  read address, valid while mem_read=1
- mem_rdata  input  16  returned instruction word
- mem_rvalid  input  1  mem_rdata valid this cycle; exactly one per request, earliest the cycle after mem_read
- instruction  output  16  instruction register, to the control state machine
- instr_valid  output  1  instruction holds an unconsumed word
- instr_ready  input  1  control state machine accepts instruction (pulsed from its decode state)
- instr_pc  output  ADDR_W  address the current instruction was fetched from
- pc_plus1  output  ADDR_W  instr_pc + 1 mod 2^ADDR_W, link value for JAL
- redirect  input  1  taken branch or jump this cycle
- redirect_target  input  ADDR_W  new fetch address, sampled when redirect=1

## Operation
- Registers:
  - fetch_pc: next address to fetch
  - instruction, instr_pc: hold the fetched word and its address
  - drop: a pending response must be discarded
  - state: IDLE, FETCH, WAIT, HOLD
- Reset (reset=0 at an edge): state=IDLE, fetch_pc=RESET_PC, instruction=16'h0000, instr_pc=RESET_PC, drop=0. Outputs while in IDLE: mem_read=0, instr_valid=0, mem_addr=fetch_pc.
- Outputs are Moore, decoded from state:
  - mem_read=1 only in FETCH
  - instr_valid=1 only in HOLD
  - mem_addr=fetch_pc always
- State transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH -> WAIT. mem_rvalid in FETCH is a protocol violation and is ignored.
  - WAIT, mem_rvalid=1 and drop=0: instruction<=mem_rdata, instr_pc<=fetch_pc, fetch_pc<=fetch_pc+1, then -> HOLD.
  - WAIT, mem_rvalid=1 and drop=1: discard the data, drop<=0, -> FETCH. fetch_pc already holds the redirect target.
  - WAIT, mem_rvalid=0: stay in WAIT.
  - HOLD, instr_ready=1: -> FETCH. fetch_pc was already advanced at capture.
  - HOLD, instr_ready=0: stay in HOLD. instruction and instr_pc stay stable.
- Redirect, any state except IDLE: fetch_pc<=redirect_target.
  - In WAIT, with no mem_rvalid that same cycle: drop<=1.
  - In WAIT with mem_rvalid the same cycle: the response is discarded, -> FETCH.
  - In HOLD: the held word is invalidated and the state goes -> FETCH, regardless of instr_ready.
  - In FETCH: the current request proceeds and drop<=1, so its response is discarded.
  - Redirect always overrides the +1 increment.
- Redirect in IDLE is ignored.
- instruction and instr_pc change only at a non-dropped capture. They stay stable while the control state machine executes a multicycle instruction.
- Arithmetic: fetch_pc+1 wraps 16'hFFFF -> 16'h0000. pc_plus1 wraps the same way.
- Only one memory request is outstanding at a time.

## Timing
- Cycle 0 is the first edge with reset=1: IDLE->FETCH. mem_read=1 during cycle 1.
- Zero-wait memory (mem_rvalid the cycle after mem_read): the word is captured at the end of that cycle, and instr_valid=1 two cycles after FETCH is entered.
- Back-to-back throughput with instr_ready held at 1: one instruction per 3 cycles (FETCH, WAIT, HOLD).
- Each memory wait cycle adds one cycle to latency. instr_ready low adds one cycle per stalled cycle.
- Redirect to the first mem_read at the target:
  - from HOLD: 1 cycle
  - from WAIT: 1 cycle after the stale mem_rvalid arrives
- Reset mid-fetch: state returns to IDLE and drop clears. A late mem_rvalid afterwards arrives in IDLE or FETCH and is ignored.

## Test plan
- Reset release, memory returns 16'h5321 at RESET_PC=0 with zero wait -> mem_read high in cycle 1 with mem_addr=0. instr_valid high in cycle 3 with instruction=16'h5321, instr_pc=0, pc_plus1=1.
- Three sequential fetches with instr_ready tied to 1 -> mem_addr sequence 0,1,2, one mem_read every 3 cycles, instr_pc 0,1,2.
- Hold instr_ready=0 for 5 cycles in HOLD -> instruction, instr_pc and instr_valid remain constant and no mem_read is issued. Next mem_read occurs 1 cycle after instr_ready=1.
- Redirect to 16'h0040 while in WAIT, memory responds 2 cycles later with 16'hDEAD -> 16'hDEAD is never presented. Next mem_addr=16'h0040, and the captured instr_pc=16'h0040.
- Redirect to 16'h0100 coincident with instr_ready in HOLD -> next mem_addr=16'h0100, not instr_pc+1.
- Fetch at fetch_pc=16'hFFFF -> instr_pc=16'hFFFF, pc_plus1=16'h0000, and the following mem_addr=16'h0000. Assert reset=0 during WAIT -> instr_valid=0, mem_read=0, and the next fetch is from RESET_PC.
